// File: rtl/dac_readback_5390.sv
// AD5390 SPI readback engine: sends a readback command frame, waits for BUSY_ release,
// then clocks a NOP frame while capturing the 24-bit register value from SDO.
module dac_readback_5390 #(
  parameter int          CLK_DIV    = 2,
  parameter int          GAP_CYCLES = 4,
  parameter int          TIMEOUT    = 1024,
  parameter logic [23:0] NOP_WORD   = 24'h000000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [23:0] cmd_i,
  output logic        ready_o,
  output logic        sclk_o,
  output logic        sync_n_o,
  output logic        sdin_o,
  input  logic        sdo_i,
  input  logic        busy_n_i,
  output logic [23:0] data_o,
  output logic        valid_o,
  output logic        error_o
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] PH_FALL = PW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, CMD, GAP, WAIT_BUSY, READ, DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [4:0]    bit_q, bit_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [23:0]   shift_q, shift_d;
  logic [23:0]   cap_q, cap_d;
  logic [23:0]   data_q, data_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          ready_q, ready_d;
  logic          sclk_q, sclk_d;
  logic          sync_n_q, sync_n_d;
  logic          sdin_q, sdin_d;
  logic          busy_meta_q, busy_meta_d;
  logic          busy_s_q, busy_s_d;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    gap_d       = gap_q;
    tmo_d       = tmo_q;
    shift_d     = shift_q;
    cap_d       = cap_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    err_d       = err_q;
    sclk_d      = sclk_q;
    sync_n_d    = sync_n_q;
    sdin_d      = sdin_q;
    busy_meta_d = busy_n_i;
    busy_s_d    = busy_meta_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = CMD;
          shift_d  = cmd_i;
          err_d    = 1'b0;
          phase_d  = '0;
          bit_d    = '0;
          sync_n_d = 1'b0;
          sclk_d   = 1'b1;
          sdin_d   = cmd_i[23];
        end
      end
      CMD, READ: begin
        // SDO is captured on the same edge that drops SCLK, i.e. the DAC's sampling edge.
        if (state_q == READ && phase_q == PH_FALL) cap_d = {cap_q[22:0], sdo_i};
        if (phase_q == PH_LAST) begin
          if (bit_q == 5'd23) begin
            sync_n_d = 1'b1;
            sclk_d   = 1'b0;
            if (state_q == CMD) begin
              state_d = GAP;
              gap_d   = '0;
            end else begin
              state_d = DONE;
              data_d  = cap_q;
              valid_d = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 5'd1;
            phase_d = '0;
            shift_d = {shift_q[22:0], 1'b0};
            sdin_d  = shift_q[22];
            sclk_d  = 1'b1;
          end
        end else begin
          phase_d = phase_q + PW'(1);
          if (phase_q == PH_FALL) sclk_d = 1'b0;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = WAIT_BUSY;
          tmo_d   = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      WAIT_BUSY: begin
        if (busy_s_q) begin
          state_d  = READ;
          shift_d  = NOP_WORD;
          cap_d    = '0;
          phase_d  = '0;
          bit_d    = '0;
          sync_n_d = 1'b0;
          sclk_d   = 1'b1;
          sdin_d   = NOP_WORD[23];
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      bit_q       <= '0;
      gap_q       <= '0;
      tmo_q       <= '0;
      shift_q     <= '0;
      cap_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      ready_q     <= 1'b1;
      sclk_q      <= 1'b0;
      sync_n_q    <= 1'b1;
      sdin_q      <= 1'b0;
      busy_meta_q <= 1'b0;
      busy_s_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      gap_q       <= gap_d;
      tmo_q       <= tmo_d;
      shift_q     <= shift_d;
      cap_q       <= cap_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      sclk_q      <= sclk_d;
      sync_n_q    <= sync_n_d;
      sdin_q      <= sdin_d;
      busy_meta_q <= busy_meta_d;
      busy_s_q    <= busy_s_d;
    end
  end

  assign ready_o  = ready_q;
  assign sclk_o   = sclk_q;
  assign sync_n_o = sync_n_q;
  assign sdin_o   = sdin_q;
  assign data_o   = data_q;
  assign valid_o  = valid_q;
  assign error_o  = err_q;

endmodule

// File: tb/tb_dac_readback_5390.sv
// Bench for dac_readback_5390: timeline model of the readback transaction, a behavioural
// DAC on the SPI pins, and directed scenarios with hand-computed expectations.
module tb_dac_readback_5390;
  localparam int CD = 2;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        start_i = 1'b0;
  logic [23:0] cmd_i = '0;
  logic        ready_o, sclk_o, sync_n_o, sdin_o, valid_o, error_o;
  logic        sdo_i = 1'b0;
  logic        busy_n_i = 1'b1;
  logic [23:0] data_o;

  dac_readback_5390 dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .cmd_i(cmd_i),
    .ready_o(ready_o), .sclk_o(sclk_o), .sync_n_o(sync_n_o), .sdin_o(sdin_o),
    .sdo_i(sdo_i), .busy_n_i(busy_n_i), .data_o(data_o), .valid_o(valid_o),
    .error_o(error_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural DAC: shifts the register word out on SCLK rising edges.
  logic [23:0] sdo_word = '0;
  int k = 0;
  int sclk_rises = 0;
  always @(posedge sclk_o) begin
    sclk_rises++;
    if (k < 24) sdo_i = sdo_word[23 - k];
    k++;
  end
  always @(posedge sync_n_o) k = 0;

  // Timeline model: cycle arithmetic from the accept cycle.
  bit          hist [int];
  bit          m_init = 0, m_active = 0, m_err = 0;
  int          m_a = 0, m_r = -1;
  logic [23:0] m_cmd = '0, m_word = '0, m_data = '0;

  always @(posedge clk) begin
    int x;
    x = cyc;
    hist[x] = busy_n_i;
    if (reset_i) begin
      m_init = 1; m_active = 0; m_data = '0; m_err = 0; m_r = -1;
    end else if (m_init) begin
      if (m_active) begin
        if (m_r < 0) begin
          if (x >= m_a + 101) begin
            if (hist.exists(x - 2) && hist[x - 2]) m_r = x + 1;
            else if (x == m_a + 101 + 1023) begin
              m_active = 0; m_err = 1;
            end
          end
        end else if (x == m_r + 96) begin
          m_active = 0; m_data = m_word;
        end
      end else if (start_i) begin
        m_active = 1; m_a = x; m_cmd = cmd_i; m_word = sdo_word; m_err = 0; m_r = -1;
      end
    end
    cyc = cyc + 1;
  end

  // Compare process plus event monitor, sampling at the falling clock edge.
  int          valid_cnt = 0, valid_cyc = 0, sync_falls = 0, last_fall = 0, err_cyc = 0;
  logic [23:0] valid_data = '0;
  logic [47:0] stream = '0;
  int          nbits = 0;
  logic        prev_sclk = 0, prev_sync = 1, prev_err = 0;

  always @(negedge clk) begin
    logic        e_ready, e_sync, e_sclk, e_valid, e_sdin, chk_sdin;
    logic [23:0] e_data, w;
    int          n, d, t;
    if (m_init) begin
      n = cyc;
      e_ready = !m_active; e_sync = 1; e_sclk = 0; e_valid = 0; e_sdin = 0; chk_sdin = 0;
      e_data = m_data;
      t = -1; w = '0;
      if (m_active) begin
        d = n - m_a;
        if (d >= 1 && d <= 96) begin
          t = d - 1; w = m_cmd;
        end else if (m_r >= 0 && n - m_r >= 0 && n - m_r < 96) begin
          t = n - m_r; w = 24'h000000;
        end else if (m_r >= 0 && n - m_r == 96) begin
          e_valid = 1; e_data = m_word;
        end
      end
      if (t >= 0) begin
        e_sync = 0; e_sclk = ((t % (2 * CD)) < CD); e_sdin = w[23 - t / (2 * CD)]; chk_sdin = 1;
      end
      tests++;
      if (ready_o !== e_ready || sync_n_o !== e_sync || sclk_o !== e_sclk ||
          valid_o !== e_valid || error_o !== m_err || data_o !== e_data ||
          (chk_sdin && sdin_o !== e_sdin)) begin
        fails++;
        if (fails <= 20)
          $display("FAIL model cyc=%0d rdy=%b/%b sync=%b/%b sclk=%b/%b sdin=%b/%b vld=%b/%b err=%b/%b data=%h/%h",
                   n, ready_o, e_ready, sync_n_o, e_sync, sclk_o, e_sclk, sdin_o, e_sdin,
                   valid_o, e_valid, error_o, m_err, data_o, e_data);
      end
    end
    if (prev_sclk && !sclk_o && !sync_n_o) begin
      stream = {stream[46:0], sdin_o}; nbits++;
    end
    if (prev_sync && !sync_n_o) begin
      sync_falls++; last_fall = cyc;
    end
    if (valid_o) begin
      valid_cnt++; valid_cyc = cyc; valid_data = data_o;
    end
    if (error_o && !prev_err) err_cyc = cyc;
    prev_sclk = sclk_o; prev_sync = sync_n_o; prev_err = error_o;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_start(input logic [23:0] cmd, input logic [23:0] word, output int acc);
    sdo_word = word; start_i = 1; cmd_i = cmd; acc = cyc;
    tick();
    start_i = 0; cmd_i = '0;
  endtask

  task automatic wait_valid(input int budget);
    int v0;
    v0 = valid_cnt;
    for (int i = 0; i < budget && valid_cnt == v0; i++) tick();
    check("valid_seen", 48'(valid_cnt != v0), 48'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, r0, f0, v0, rise;
    tick(3);
    reset_i = 0;

    // Idle after reset
    r0 = sclk_rises; f0 = sync_falls;
    tick(50);
    check("idle_sclk_rises", 48'(sclk_rises - r0), 48'd0);
    check("idle_sync_falls", 48'(sync_falls - f0), 48'd0);
    check("idle_ready", 48'(ready_o), 48'd1);
    check("idle_sync", 48'(sync_n_o), 48'd1);
    check("idle_data", 48'(data_o), 48'd0);

    // Basic readback, BUSY_ already released
    nbits = 0; stream = '0; r0 = sclk_rises;
    do_start(24'h8C0000, 24'hA5C3F0, a);
    wait_valid(300);
    tick(4);
    check("basic_valid_cycle", 48'(valid_cyc - a), 48'd198);
    check("basic_data", 48'(valid_data), 48'hA5C3F0);
    check("basic_sclk_rises", 48'(sclk_rises - r0), 48'd48);
    check("basic_stream", stream, 48'h8C0000_000000);
    check("basic_nbits", 48'(nbits), 48'd48);

    // BUSY_ held low 300 cycles after GAP, then released
    busy_n_i = 0;
    do_start(24'h9A5A5A, 24'h3C5A96, a);
    wait_until(a + 401);
    busy_n_i = 1; rise = cyc;
    wait_valid(200);
    tick(2);
    check("busy_read_delay", 48'(last_fall - rise), 48'd3);
    check("busy_data", 48'(data_o), 48'h3C5A96);

    // Timeout: BUSY_ never released
    busy_n_i = 0; v0 = valid_cnt;
    do_start(24'hC00001, 24'h777777, a);
    for (int i = 0; i < 1300 && !error_o; i++) tick();
    tick(5);
    check("tmo_err_cycle", 48'(err_cyc - a), 48'd1125);
    check("tmo_error", 48'(error_o), 48'd1);
    check("tmo_no_valid", 48'(valid_cnt - v0), 48'd0);
    check("tmo_data_kept", 48'(data_o), 48'h3C5A96);
    check("tmo_ready", 48'(ready_o), 48'd1);
    busy_n_i = 1;
    tick(3);
    do_start(24'h800000, 24'h123456, a);
    check("tmo_err_cleared", 48'(error_o), 48'd0);
    wait_valid(300);
    tick(2);
    check("after_tmo_data", 48'(data_o), 48'h123456);

    // Reset in the middle of the read frame
    v0 = valid_cnt;
    do_start(24'h8C0000, 24'hFFFFFF, a);
    wait_until(a + 150);
    reset_i = 1;
    tick();
    check("rst_sync", 48'(sync_n_o), 48'd1);
    check("rst_sclk", 48'(sclk_o), 48'd0);
    check("rst_ready", 48'(ready_o), 48'd1);
    check("rst_data", 48'(data_o), 48'd0);
    reset_i = 0;
    tick(250);
    check("rst_no_valid", 48'(valid_cnt - v0), 48'd0);

    // Start pulses during CMD and READ are ignored
    nbits = 0; stream = '0; r0 = sclk_rises; v0 = valid_cnt;
    do_start(24'hC1A2B3, 24'h5A5A5A, a);
    wait_until(a + 20);
    start_i = 1; cmd_i = 24'hFFFFFF; tick(); start_i = 0; cmd_i = '0;
    wait_until(a + 130);
    start_i = 1; cmd_i = 24'hFFFFFF; tick(); start_i = 0; cmd_i = '0;
    wait_valid(200);
    tick(20);
    check("ign_valid_count", 48'(valid_cnt - v0), 48'd1);
    check("ign_valid_cycle", 48'(valid_cyc - a), 48'd198);
    check("ign_stream", stream, 48'hC1A2B3_000000);
    check("ign_data", 48'(data_o), 48'h5A5A5A);
    check("ign_sclk_rises", 48'(sclk_rises - r0), 48'd48);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
